// File: rtl/dshot_arming_if.sv
// DShot arming controller bus: decoded-frame inputs from the DShot decoder and
// the gated motor-control outputs toward the PWM/ESC stage.
// Optional macro DSHOT_ARM_ERR_COUNT_EN adds the 16-bit err_count output.
interface dshot_arming_if;
    logic        frame_strobe;
    logic [10:0] frame_value;
    logic        frame_crc_ok;
    logic [10:0] throttle_out;
    logic        armed;
    logic        failsafe;
    logic        cmd_strobe;
    logic [5:0]  cmd_code;
    logic        motor_reverse;
`ifdef DSHOT_ARM_ERR_COUNT_EN
    logic [15:0] err_count;
`endif

    // Decoder / bench side: drives frames, observes controller outputs
    modport master (
        output frame_strobe, frame_value, frame_crc_ok,
        input  throttle_out, armed, failsafe, cmd_strobe, cmd_code, motor_reverse
`ifdef DSHOT_ARM_ERR_COUNT_EN
        , input err_count
`endif
    );

    // Controller side
    modport slave (
        input  frame_strobe, frame_value, frame_crc_ok,
        output throttle_out, armed, failsafe, cmd_strobe, cmd_code, motor_reverse
`ifdef DSHOT_ARM_ERR_COUNT_EN
        , output err_count
`endif
    );
endinterface

// File: rtl/dshot_arming_controller.sv
// DShot arming controller: arming sequence, throttle gating, special-command
// qualification and link-loss failsafe. All outputs are registered.
// Optional macro DSHOT_ARM_ERR_COUNT_EN adds a saturating bad-CRC frame counter.
module dshot_arming_controller #(
    parameter int TIMEOUT_CYCLES = 16000,
    parameter int ARM_FRAMES     = 10,
    parameter int CMD_REPEAT     = 6
) (
    input logic            clk,
    input logic            reset,
    dshot_arming_if.slave  bus
);
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int ARM_W = $clog2(ARM_FRAMES + 1);
    localparam int CMD_W = $clog2(CMD_REPEAT + 1);

    localparam logic [TW-1:0]    TIMER_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [ARM_W-1:0] ARM_LAST  = ARM_W'(ARM_FRAMES - 1);
    localparam logic [CMD_W-1:0] CMD_MAX   = CMD_W'(CMD_REPEAT);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_FAILSAFE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
    logic [CMD_W-1:0] cmd_cnt_q, cmd_cnt_d;
    logic [5:0]       cmd_last_q, cmd_last_d;
    logic [10:0]      throttle_q, throttle_d;
    logic             armed_q, armed_d;
    logic             failsafe_q, failsafe_d;
    logic             cmd_strobe_q, cmd_strobe_d;
    logic [5:0]       cmd_code_q, cmd_code_d;
    logic             reverse_q, reverse_d;

    logic             accept, crc_bad, is_cmd, timeout_hit, new_code, fire;
    logic [10:0]      v;

`ifdef DSHOT_ARM_ERR_COUNT_EN
    logic [15:0]      err_cnt_q, err_cnt_d;
`endif

    // Next-state computation for timer, FSM, arming and command qualification
    always_comb begin
        v        = bus.frame_value;
        accept   = bus.frame_strobe & bus.frame_crc_ok;
        crc_bad  = bus.frame_strobe & ~bus.frame_crc_ok;
        is_cmd   = accept && (v != 11'd0) && (v < 11'd48);

        // Link-loss timer: any good frame restarts it, otherwise count to saturation
        if (accept)                  timer_d = '0;
        else if (timer_q != TIMER_MAX) timer_d = timer_q + 1'b1;
        else                         timer_d = timer_q;
        timeout_hit = (timer_d == TIMER_MAX);

        state_d      = state_q;
        arm_cnt_d    = arm_cnt_q;
        cmd_cnt_d    = cmd_cnt_q;
        cmd_last_d   = cmd_last_q;
        throttle_d   = throttle_q;
        cmd_strobe_d = 1'b0;
        cmd_code_d   = cmd_code_q;
        reverse_d    = reverse_q;
        new_code     = 1'b0;
        fire         = 1'b0;

        case (state_q)
            ST_DISARMED: begin
                throttle_d = '0;
                if (accept && v == 11'd0) begin
                    if (arm_cnt_q == ARM_LAST) begin
                        state_d   = ST_ARMED;
                        arm_cnt_d = '0;
                    end else begin
                        arm_cnt_d = arm_cnt_q + 1'b1;
                    end
                end else if (bus.frame_strobe) begin
                    arm_cnt_d = '0;
                end
                if (timeout_hit) arm_cnt_d = '0;
            end
            ST_ARMED: begin
                arm_cnt_d = '0;
                if (accept) throttle_d = (v >= 11'd48) ? (v - 11'd48) : 11'd0;
                if (timeout_hit) begin
                    state_d    = ST_FAILSAFE;
                    throttle_d = '0;
                end
            end
            ST_FAILSAFE: begin
                throttle_d = '0;
                if (accept && v == 11'd0) begin
                    state_d   = ST_DISARMED;
                    arm_cnt_d = ARM_W'(1);
                end
            end
            default: begin
                state_d    = ST_DISARMED;
                throttle_d = '0;
                arm_cnt_d  = '0;
            end
        endcase

        // Command run tracking; a run fires once when it first reaches CMD_REPEAT
        if (state_q == ST_FAILSAFE) begin
            cmd_cnt_d = '0;
        end else if (is_cmd) begin
            if (v[5:0] == cmd_last_q) begin
                cmd_cnt_d = (cmd_cnt_q == CMD_MAX) ? cmd_cnt_q : cmd_cnt_q + 1'b1;
            end else begin
                new_code   = 1'b1;
                cmd_last_d = v[5:0];
                cmd_cnt_d  = CMD_W'(1);
            end
            fire = (cmd_cnt_d == CMD_MAX) && (new_code || cmd_cnt_q != CMD_MAX);
        end else if (bus.frame_strobe) begin
            cmd_cnt_d = '0;
        end

        if (fire) begin
            cmd_strobe_d = 1'b1;
            cmd_code_d   = v[5:0];
            // Direction changes only with the motor stopped
            if (throttle_q == 11'd0) begin
                if (v == 11'd20) reverse_d = 1'b0;
                if (v == 11'd21) reverse_d = 1'b1;
            end
        end

        armed_d    = (state_d == ST_ARMED);
        failsafe_d = timeout_hit;

`ifdef DSHOT_ARM_ERR_COUNT_EN
        err_cnt_d = err_cnt_q;
        if (crc_bad && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 1'b1;
`endif
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_DISARMED;
            timer_q      <= '0;
            arm_cnt_q    <= '0;
            cmd_cnt_q    <= '0;
            cmd_last_q   <= '0;
            throttle_q   <= '0;
            armed_q      <= 1'b0;
            failsafe_q   <= 1'b0;
            cmd_strobe_q <= 1'b0;
            cmd_code_q   <= '0;
            reverse_q    <= 1'b0;
`ifdef DSHOT_ARM_ERR_COUNT_EN
            err_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            arm_cnt_q    <= arm_cnt_d;
            cmd_cnt_q    <= cmd_cnt_d;
            cmd_last_q   <= cmd_last_d;
            throttle_q   <= throttle_d;
            armed_q      <= armed_d;
            failsafe_q   <= failsafe_d;
            cmd_strobe_q <= cmd_strobe_d;
            cmd_code_q   <= cmd_code_d;
            reverse_q    <= reverse_d;
`ifdef DSHOT_ARM_ERR_COUNT_EN
            err_cnt_q    <= err_cnt_d;
`endif
        end
    end

    assign bus.throttle_out  = throttle_q;
    assign bus.armed         = armed_q;
    assign bus.failsafe      = failsafe_q;
    assign bus.cmd_strobe    = cmd_strobe_q;
    assign bus.cmd_code      = cmd_code_q;
    assign bus.motor_reverse = reverse_q;
`ifdef DSHOT_ARM_ERR_COUNT_EN
    assign bus.err_count     = err_cnt_q;
`endif

    logic unused_crc_bad;
    assign unused_crc_bad = crc_bad;
endmodule

// File: tb/tb_dshot_arming_controller.sv
// Bench for dshot_arming_controller: a table of per-cycle frames with the
// outputs expected one edge later, checked through a scoreboard queue.
module tb_dshot_arming_controller;
    localparam int TMO = 20;

    typedef struct {
        logic        rst;
        logic        stb;
        logic [10:0] val;
        logic        crc;
        logic [10:0] thr;
        logic        arm;
        logic        fs;
        logic        cs;
        logic [5:0]  code;
        logic        rev;
        logic [15:0] err;
        int          idx;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    dshot_arming_if bus();

    dshot_arming_controller #(.TIMEOUT_CYCLES(TMO), .ARM_FRAMES(10), .CMD_REPEAT(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    vec_t vecs[$];
    vec_t sb[$];
    int   applied = 0;
    int   miscompares = 0;
    logic [15:0] err_model = '0;

    function automatic void add(input logic rst, input logic stb, input int val, input logic crc,
                                input int thr, input logic arm, input logic fs, input logic cs,
                                input int code, input logic rev);
        vec_t e;
        e.rst = rst; e.stb = stb; e.val = 11'(val); e.crc = crc;
        e.thr = 11'(thr); e.arm = arm; e.fs = fs; e.cs = cs; e.code = 6'(code); e.rev = rev;
        if (rst) err_model = '0;
        else if (stb && !crc) err_model = err_model + 16'd1;
        e.err = err_model;
        e.idx = vecs.size();
        vecs.push_back(e);
    endfunction

    task automatic check(input vec_t e);
        logic bad;
        bad = (bus.throttle_out !== e.thr) || (bus.armed !== e.arm) || (bus.failsafe !== e.fs) ||
              (bus.cmd_strobe !== e.cs) || (bus.cmd_code !== e.code) || (bus.motor_reverse !== e.rev);
`ifdef DSHOT_ARM_ERR_COUNT_EN
        if (bus.err_count !== e.err) bad = 1'b1;
`endif
        applied++;
        if (bad) begin
            miscompares++;
            $display("FAIL vec%0d: got thr=%0d arm=%b fs=%b cs=%b code=%0d rev=%b, want thr=%0d arm=%b fs=%b cs=%b code=%0d rev=%b err=%0d",
                     e.idx, bus.throttle_out, bus.armed, bus.failsafe, bus.cmd_strobe, bus.cmd_code,
                     bus.motor_reverse, e.thr, e.arm, e.fs, e.cs, e.code, e.rev, e.err);
        end
    endtask

    initial begin
        bus.frame_strobe = 1'b0;
        bus.frame_value  = '0;
        bus.frame_crc_ok = 1'b0;

        // reset, then reset-state check
        repeat (2) add(1, 0, 0, 1,   0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1,              0, 0, 0, 0, 0, 0);
        // 9 zeros then a throttle frame: no arm; the count restarts from zero
        repeat (9) add(0, 1, 0, 1,   0, 0, 0, 0, 0, 0);
        add(0, 1, 100, 1,            0, 0, 0, 0, 0, 0);
        repeat (9) add(0, 1, 0, 1,   0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1,              0, 1, 0, 0, 0, 0);
        // throttle mapping while armed
        add(0, 1, 1048, 1,        1000, 1, 0, 0, 0, 0);
        add(0, 1, 30, 1,             0, 1, 0, 0, 0, 0);
        add(0, 1, 2047, 1,        1999, 1, 0, 0, 0, 0);
        add(0, 1, 48, 1,             0, 1, 0, 0, 0, 0);
        add(0, 1, 548, 1,          500, 1, 0, 0, 0, 0);
        // bad CRC: throttle held and the timer keeps running
        add(0, 1, 1048, 0,         500, 1, 0, 0, 0, 0);
        repeat (TMO - 2) add(0, 0, 0, 1, 500, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1,              0, 0, 1, 0, 0, 0);
        // failsafe: non-zero frame ignored, zero frame disarms with one count credited
        add(0, 1, 1000, 1,           0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1,              0, 0, 0, 0, 0, 0);
        repeat (8) add(0, 1, 0, 1,   0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1,              0, 1, 0, 0, 0, 0);
        // broken run of 21, then a full run, a repeat, and a run of 20
        repeat (5) add(0, 1, 21, 1,  0, 1, 0, 0, 0, 0);
        add(0, 1, 20, 1,             0, 1, 0, 0, 0, 0);
        repeat (5) add(0, 1, 21, 1,  0, 1, 0, 0, 0, 0);
        add(0, 1, 21, 1,             0, 1, 0, 1, 21, 1);
        add(0, 1, 21, 1,             0, 1, 0, 0, 21, 1);
        repeat (5) add(0, 1, 20, 1,  0, 1, 0, 0, 21, 1);
        add(0, 1, 20, 1,             0, 1, 0, 1, 20, 0);
        // reset while running at throttle 800
        add(0, 1, 848, 1,          800, 1, 0, 0, 20, 0);
        add(1, 0, 0, 1,              0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1,              0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (sb.size() > 0) check(sb.pop_front());
            reset            = vecs[i].rst;
            bus.frame_strobe = vecs[i].stb;
            bus.frame_value  = vecs[i].val;
            bus.frame_crc_ok = vecs[i].crc;
            sb.push_back(vecs[i]);
        end
        @(negedge clk);
        if (sb.size() > 0) check(sb.pop_front());
        reset            = 1'b0;
        bus.frame_strobe = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
